rtl_bias_seq: RTL and testbench
===============================

Name: rtl_bias_seq

Overview:
Sequencer and collector that drives one bias PE and captures its results. Holds N bias words in a register bank. On start, it walks neuron indices 0..N-1; for each index it accepts one sum_in/delta_k pair, presents the stored bias to the PE, and waits out the PE latency. It then emits net_sum and, in training mode, writes bias_change back into the bank. Sits between the layer datapath (upstream sum/delta stream) and the bias PE outputs (return_array_1 = net_sum, return_array_0 = bias_change).

Parameters:
N_NEURON, 4, number of bias entries / neurons per pass
IDX_W, 2, index width, at least clog2(N_NEURON)
PE_LAT, 1, PE pipeline latency in ap_ce-qualified cycles, at least 1
INIT_BIAS, 16'h0000, reset value of every bias entry

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
ap_ce  in  1  clock enable; when low, all state, counters and outputs hold
start  in  1  begin a pass; sampled only in IDLE
training  in  1  latched at start; enables bias writeback
eta  in  16  learning rate, fixed_16; latched at start
sum_in_vld  in  1  upstream sum/delta valid
sum_in_rdy  out  1  upstream ready
sum_in  in  16  neuron input sum
delta_k  in  16  neuron error term
load_en  in  1  bias preload strobe, honoured only in IDLE
load_idx  in  IDX_W  preload index
load_val  in  16  preload value
pe_init_bias  out  16  to PE init_bias
pe_sum_in  out  16  to PE sum_in
pe_delta_k  out  16  to PE delta_k
pe_eta  out  16  to PE eta
pe_training  out  16  to PE training, {15'b0, training_latched}
pe_net_sum  in  16  from PE return_array_1
pe_bias_change  in  16  from PE return_array_0
net_sum_vld  out  1  one-cycle result strobe
net_sum  out  16  captured net sum
net_idx  out  IDX_W  index of net_sum
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at end of pass

Behaviour:
- Reset (ap_rst=1 at posedge, regardless of ap_ce): state=IDLE; all bias entries=INIT_BIAS; all pe_* registers, net_sum, net_idx, counters=0; sum_in_rdy, net_sum_vld, busy, done=0. Reset mid-pass aborts the pass and discards any pending writeback.
- All transitions are qualified by ap_ce=1. When ap_ce=0, everything holds, including single-cycle strobes.
- FSM: IDLE -> ISSUE -> WAIT -> CAPTURE -> (ISSUE for the next index | DONE) -> IDLE.
- IDLE: if load_en=1, bias[load_idx] <= load_val. If start=1, latch training and eta, set idx=0, go to ISSUE. If load_en and start occur in the same cycle, the load is performed first and is visible to the pass.
- ISSUE: sum_in_rdy=1. On sum_in_vld=1, register pe_sum_in<=sum_in, pe_delta_k<=delta_k, pe_init_bias<=bias[idx], pe_eta<=eta_latched, clear the wait counter, go to WAIT. If vld=0, stay in ISSUE.
- WAIT: hold pe_* values. Count PE_LAT cycles, then go to CAPTURE. With acceptance at cycle t, CAPTURE is at cycle t+1+PE_LAT (t+2 for PE_LAT=1).
- CAPTURE: net_sum<=pe_net_sum, net_idx<=idx, net_sum_vld=1 for exactly the next cycle. If training_latched=1, bias[idx]<=pe_bias_change; otherwise the bias is unchanged. If idx=N_NEURON-1 go to DONE, else idx+1 and go to ISSUE.
- DONE: done=1 for one cycle, busy drops, return to IDLE. Back-to-back start is accepted in the following IDLE cycle.
- start while busy: ignored. load_en while busy: ignored, bank unchanged.
- Throughput: 2+PE_LAT cycles per neuron when sum_in_vld is held high.
- Arithmetic is performed by the PE in 16-bit two's-complement with wrap-around. The sequencer stores results verbatim; no saturation.

Test Plan:
- Reset, then preload bias[0]=0x0010, start with training=1, eta=0x0003; feed sum_in=0x0005, delta_k=0x0002 with PE model attached -> net_sum=0x0015 with net_idx=0 at t+2; bias[0] becomes 0x000A.
- training=0, same stimulus -> net_sum=0x0015; bias[0] stays 0x0010 on a second pass.
- Wrap: bias[1]=0x0000, delta_k=0x0001, eta=0x0001, training=1 -> bias[1]=0xFFFF.
- Full pass of N=4 with sum_in_vld held high -> 4 net_sum_vld strobes 3 cycles apart with idx 0..3; done 1 cycle after the last; busy low afterwards. With vld gaps, sum_in_rdy stays high in ISSUE and no strobe is emitted until data arrives.
- ap_ce low for 5 cycles during WAIT -> capture delayed by exactly 5 cycles; values unchanged.
- ap_rst asserted in WAIT during a training pass -> IDLE next cycle; all biases equal INIT_BIAS; no done pulse; start and load_en during busy have no effect.

Source files
------------

// File: rtl/rtl_bias_seq.sv
// -----------------------------------------------------------------------------
// rtl_bias_seq
//
// Purpose:
//   Sequencer/collector wrapped around a single bias processing element (PE).
//   Keeps a bank of N_NEURON bias words. A pass walks neuron indices
//   0..N_NEURON-1. For each index it:
//     1. accepts one sum_in/delta_k pair from the upstream stream,
//     2. presents that pair, the stored bias and the latched eta to the PE,
//     3. waits out the PE latency,
//     4. captures net_sum and, in training mode, writes bias_change back into
//        the bank.
//
// Handshake (upstream sum/delta stream):
//   A word transfers on a rising ap_clk edge where ap_ce=1, sum_in_vld=1 and
//   sum_in_rdy=1. sum_in_rdy is high for the whole ISSUE state and low
//   everywhere else; it does not depend on sum_in_vld. The producer may hold
//   sum_in_vld high across non-ISSUE cycles; nothing is taken until ISSUE.
//
// Clock enable:
//   When ap_ce=0 every register holds, including the one-cycle strobes
//   net_sum_vld and done. Reset is honoured regardless of ap_ce.
//
// Ports:
//   ap_clk, ap_rst, ap_ce          clock, synchronous active-high reset, enable
//   start, training, eta           pass control; training/eta latched at start
//   sum_in_vld/sum_in_rdy          upstream handshake
//   sum_in, delta_k                upstream payload
//   load_en, load_idx, load_val    bias preload, honoured only in IDLE
//   pe_init_bias .. pe_training    registered operands driven to the PE
//   pe_net_sum, pe_bias_change     PE results (return_array_1 / return_array_0)
//   net_sum_vld, net_sum, net_idx  captured result and its neuron index
//   busy, done                     pass status
//   dbg_state                      current FSM state encoding (state_t)
// -----------------------------------------------------------------------------
module rtl_bias_seq #(
    parameter int          N_NEURON  = 4,
    parameter int          IDX_W     = 2,
    parameter int          PE_LAT    = 1,
    parameter logic [15:0] INIT_BIAS = 16'h0000
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_ce,
    input  logic             start,
    input  logic             training,
    input  logic [15:0]      eta,
    input  logic             sum_in_vld,
    output logic             sum_in_rdy,
    input  logic [15:0]      sum_in,
    input  logic [15:0]      delta_k,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [15:0]      load_val,
    output logic [15:0]      pe_init_bias,
    output logic [15:0]      pe_sum_in,
    output logic [15:0]      pe_delta_k,
    output logic [15:0]      pe_eta,
    output logic [15:0]      pe_training,
    input  logic [15:0]      pe_net_sum,
    input  logic [15:0]      pe_bias_change,
    output logic             net_sum_vld,
    output logic [15:0]      net_sum,
    output logic [IDX_W-1:0] net_idx,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    // Wait counter only has to reach PE_LAT-1.
    localparam int CNT_W = (PE_LAT < 2) ? 1 : $clog2(PE_LAT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           r_state;
    logic [15:0]      r_bias [N_NEURON];
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_training;
    logic [15:0]      r_eta;

    logic [15:0]      r_pe_init_bias;
    logic [15:0]      r_pe_sum_in;
    logic [15:0]      r_pe_delta_k;
    logic [15:0]      r_pe_eta;

    logic             r_sum_in_rdy;
    logic             r_net_sum_vld;
    logic [15:0]      r_net_sum;
    logic [IDX_W-1:0] r_net_idx;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_last_idx;
    logic             w_wait_over;

    assign w_accept    = r_sum_in_rdy && sum_in_vld;
    assign w_last_idx  = (r_idx == IDX_W'(N_NEURON - 1));
    assign w_wait_over = (r_wait_cnt == CNT_W'(PE_LAT - 1));

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state        <= S_IDLE;
            for (int i = 0; i < N_NEURON; i++) begin
                r_bias[i] <= INIT_BIAS;
            end
            r_idx          <= '0;
            r_wait_cnt     <= '0;
            r_training     <= 1'b0;
            r_eta          <= '0;
            r_pe_init_bias <= '0;
            r_pe_sum_in    <= '0;
            r_pe_delta_k   <= '0;
            r_pe_eta       <= '0;
            r_sum_in_rdy   <= 1'b0;
            r_net_sum_vld  <= 1'b0;
            r_net_sum      <= '0;
            r_net_idx      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else if (ap_ce) begin
            // Strobes default low; the state that raises them overrides below.
            r_net_sum_vld <= 1'b0;
            r_done        <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // The load lands on the same edge that starts the pass,
                    // so a simultaneous load is already in the bank by the
                    // time ISSUE reads it. load_idx beyond N_NEURON-1 (only
                    // possible when IDX_W is wider than needed) writes nothing.
                    if (load_en) begin
                        r_bias[load_idx] <= load_val;
                    end
                    if (start) begin
                        r_training   <= training;
                        r_eta        <= eta;
                        r_idx        <= '0;
                        r_sum_in_rdy <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (w_accept) begin
                        r_pe_sum_in    <= sum_in;
                        r_pe_delta_k   <= delta_k;
                        r_pe_init_bias <= r_bias[r_idx];
                        r_pe_eta       <= r_eta;
                        r_wait_cnt     <= '0;
                        r_sum_in_rdy   <= 1'b0;
                        r_state        <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // PE operands stay frozen here; the PE result is valid in
                    // the CAPTURE cycle after PE_LAT enabled cycles.
                    if (w_wait_over) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end

                S_CAPTURE: begin
                    r_net_sum     <= pe_net_sum;
                    r_net_idx     <= r_idx;
                    r_net_sum_vld <= 1'b1;
                    if (r_training) begin
                        r_bias[r_idx] <= pe_bias_change;
                    end
                    if (w_last_idx) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx        <= r_idx + IDX_W'(1);
                        r_sum_in_rdy <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end

                S_DONE: begin
                    // done and the busy drop both appear in the first IDLE
                    // cycle, which is also where a back-to-back start is taken.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_sum_in_rdy <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign sum_in_rdy   = r_sum_in_rdy;
    assign pe_init_bias = r_pe_init_bias;
    assign pe_sum_in    = r_pe_sum_in;
    assign pe_delta_k   = r_pe_delta_k;
    assign pe_eta       = r_pe_eta;
    assign pe_training  = {15'b0, r_training};
    assign net_sum_vld  = r_net_sum_vld;
    assign net_sum      = r_net_sum;
    assign net_idx      = r_net_idx;
    assign busy         = r_busy;
    assign done         = r_done;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_rtl_bias_seq.sv
`timescale 1ns/1ps
module tb_rtl_bias_seq;

  localparam int N = 4;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd2;

  // ---------------------------------------------------------------- clock/reset
  logic ap_clk = 1'b0;
  logic ap_rst, ap_ce, start, training;
  logic [15:0] eta, sum_in, delta_k, load_val;
  logic sum_in_vld, sum_in_rdy, load_en;
  logic [1:0] load_idx, net_idx;
  logic [15:0] pe_init_bias, pe_sum_in, pe_delta_k, pe_eta, pe_training;
  logic [15:0] pe_net_sum, pe_bias_change, net_sum;
  logic net_sum_vld, busy, done;
  logic [2:0] dbg_state;

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  rtl_bias_seq #(.N_NEURON(4), .IDX_W(2), .PE_LAT(1), .INIT_BIAS(16'h0000)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_ce(ap_ce),
    .start(start), .training(training), .eta(eta),
    .sum_in_vld(sum_in_vld), .sum_in_rdy(sum_in_rdy),
    .sum_in(sum_in), .delta_k(delta_k),
    .load_en(load_en), .load_idx(load_idx), .load_val(load_val),
    .pe_init_bias(pe_init_bias), .pe_sum_in(pe_sum_in), .pe_delta_k(pe_delta_k),
    .pe_eta(pe_eta), .pe_training(pe_training),
    .pe_net_sum(pe_net_sum), .pe_bias_change(pe_bias_change),
    .net_sum_vld(net_sum_vld), .net_sum(net_sum), .net_idx(net_idx),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // One-stage bias PE: net = sum + bias, new bias = bias - eta*delta (wrapping).
  always @(posedge ap_clk) begin
    if (ap_rst) begin
      pe_net_sum     <= '0;
      pe_bias_change <= '0;
    end else if (ap_ce) begin
      pe_net_sum     <= pe_sum_in + pe_init_bias;
      pe_bias_change <= pe_init_bias - 16'(pe_eta * pe_delta_k);
    end
  end

  // ---------------------------------------------------------------- scoreboard
  logic [17:0] exp_q[$];      // {net_idx, net_sum}
  int          exp_cyc_q[$];  // cycle at which the strobe must be seen
  int errors = 0;
  int checks = 0;
  int last_strobe_cyc = 0;
  logic        cur_tr;
  logic [15:0] cur_eta;
  logic [17:0] mon_e;
  int          mon_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge ap_clk) begin
    if (ap_rst === 1'b0 && net_sum_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got idx %0d sum %h with empty queue (cycle %0d)", net_idx, net_sum, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        check("net_sum", 32'(net_sum), 32'(mon_e[15:0]));
        check("net_idx", 32'(net_idx), 32'(mon_e[17:16]));
        check("strobe_cycle", cyc, mon_c);
      end
      last_strobe_cyc = cyc;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic begin_pass(input logic tr, input logic [15:0] e, input logic ld,
                            input logic [1:0] li, input logic [15:0] lv, output int s);
    start = 1'b1; training = tr; eta = e;
    load_en = ld; load_idx = li; load_val = lv;
    cur_tr = tr; cur_eta = e; s = cyc;
    @(negedge ap_clk);
    start = 1'b0; load_en = 1'b0;
    training = ~tr; eta = ~e;  // must not leak into the running pass
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic feed(input logic [1:0] idx, input logic [15:0] s, input logic [15:0] d,
                      input logic [15:0] exp_net, input int gap, input int stall);
    int t;
    int c;
    logic [15:0] b;
    t = 0;
    b = exp_net - s;
    if (gap > 0) sum_in_vld = 1'b0;
    while (sum_in_rdy !== 1'b1 && t < 50) begin
      @(negedge ap_clk);
      t++;
    end
    if (sum_in_rdy !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got rdy %b expected 1 for idx %0d", sum_in_rdy, idx);
      return;
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge ap_clk);
      check("rdy_hold_in_gap", 32'(sum_in_rdy), 32'd1);
    end
    sum_in_vld = 1'b1; sum_in = s; delta_k = d;
    c = cyc;
    exp_q.push_back({idx, exp_net});
    exp_cyc_q.push_back(c + 3 + stall);
    @(negedge ap_clk);
    check("pe_sum_in", 32'(pe_sum_in), 32'(s));
    check("pe_delta_k", 32'(pe_delta_k), 32'(d));
    check("pe_init_bias", 32'(pe_init_bias), 32'(b));
    check("pe_eta", 32'(pe_eta), 32'(cur_eta));
    check("pe_training", 32'(pe_training), 32'(cur_tr));
    check("rdy_low_after_accept", 32'(sum_in_rdy), 32'd0);
    if (stall > 0) begin
      ap_ce = 1'b0;
      repeat (stall) @(negedge ap_clk);
      check("state_held_ce_low", 32'(dbg_state), 32'(ST_WAIT));
      check("pe_sum_in_held_ce_low", 32'(pe_sum_in), 32'(s));
      ap_ce = 1'b1;
    end
  endtask

  task automatic wait_done(input int s, input logic strict);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 200) begin
      @(negedge ap_clk);
      t++;
    end
    check("done_seen", 32'(done), 32'd1);
    if (done === 1'b1) begin
      if (strict) check("pass_cycles", cyc - s, 2 + 3 * N);
      check("done_after_last_strobe", cyc - last_strobe_cyc, 1);
      check("busy_at_done", 32'(busy), 32'd0);
      check("queue_empty", exp_q.size(), 0);
    end
  endtask

  // ---------------------------------------------------------------- vectors
  // Arrays are packed [3:0][15:0]: the right-most word is neuron 0.
  typedef struct packed {
    logic             ld_en;
    logic [1:0]       ld_idx;
    logic [15:0]      ld_val;
    logic             tr;
    logic [15:0]      eta;
    logic             gappy;
    logic [3:0][15:0] s;
    logic [3:0][15:0] d;
    logic [3:0][15:0] exp_net;
  } vec_t;

  vec_t tbl[7];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int s;
    int t;
    // bias bank before each pass is noted on the right
    tbl[0] = '{1'b1, 2'd0, 16'h0010, 1'b1, 16'h0003, 1'b0,   // {10,0,0,0}
               {16'hFFFF, 16'h0100, 16'h0007, 16'h0005},
               {16'h0000, 16'h0000, 16'h0000, 16'h0002},
               {16'hFFFF, 16'h0100, 16'h0007, 16'h0015}};
    tbl[1] = '{1'b1, 2'd0, 16'h0010, 1'b0, 16'h0003, 1'b1,   // {A,0,0,0} -> load 10
               {16'h0001, 16'h0000, 16'h0000, 16'h0005},
               {16'h0005, 16'h0005, 16'h0005, 16'h0002},
               {16'h0001, 16'h0000, 16'h0000, 16'h0015}};
    tbl[2] = '{1'b0, 2'd0, 16'h0000, 1'b0, 16'h0003, 1'b0,   // {10,0,0,0}
               {16'h0000, 16'h0000, 16'h0000, 16'h0005},
               {16'h0002, 16'h0002, 16'h0002, 16'h0002},
               {16'h0000, 16'h0000, 16'h0000, 16'h0015}};
    tbl[3] = '{1'b0, 2'd0, 16'h0000, 1'b1, 16'h0001, 1'b1,   // {10,0,0,0}
               {16'h0000, 16'h0000, 16'h0000, 16'h0000},
               {16'h0000, 16'h0000, 16'h0001, 16'h0000},
               {16'h0000, 16'h0000, 16'h0000, 16'h0010}};
    tbl[4] = '{1'b0, 2'd0, 16'h0000, 1'b0, 16'h0001, 1'b0,   // {10,FFFF,0,0}
               {16'h0000, 16'h0000, 16'h0000, 16'h0000},
               {16'h0000, 16'h0000, 16'h0000, 16'h0000},
               {16'h0000, 16'h0000, 16'hFFFF, 16'h0010}};
    tbl[5] = '{1'b0, 2'd0, 16'h0000, 1'b1, 16'h0002, 1'b1,   // {10,FFFF,0,0}
               {16'h0001, 16'h0001, 16'h0001, 16'h0001},
               {16'h0000, 16'hFFFF, 16'h0003, 16'h8000},
               {16'h0001, 16'h0001, 16'h0000, 16'h0011}};
    tbl[6] = '{1'b0, 2'd0, 16'h0000, 1'b0, 16'h0000, 1'b0,   // {10,FFF9,2,0}
               {16'h0000, 16'hFFFF, 16'h0001, 16'h7FFF},
               {16'h0000, 16'h0000, 16'h0000, 16'h0000},
               {16'h0000, 16'h0001, 16'hFFFA, 16'h800F}};

    ap_rst = 1'b1; ap_ce = 1'b0; start = 1'b0; training = 1'b0; eta = '0;
    sum_in_vld = 1'b0; sum_in = '0; delta_k = '0;
    load_en = 1'b0; load_idx = '0; load_val = '0;
    cur_tr = 1'b0; cur_eta = '0;

    // Reset with ap_ce low must still take effect.
    repeat (3) @(negedge ap_clk);
    check("rst_rdy", 32'(sum_in_rdy), 32'd0);
    check("rst_vld", 32'(net_sum_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_net_sum", 32'(net_sum), 32'd0);
    check("rst_net_idx", 32'(net_idx), 32'd0);
    check("rst_pe_bias", 32'(pe_init_bias), 32'd0);
    check("rst_pe_sum", 32'(pe_sum_in), 32'd0);
    check("rst_pe_delta", 32'(pe_delta_k), 32'd0);
    check("rst_pe_eta", 32'(pe_eta), 32'd0);
    check("rst_pe_training", 32'(pe_training), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    ap_rst = 1'b0; ap_ce = 1'b1;
    @(negedge ap_clk);

    // Table passes, started back-to-back in the done cycle.
    for (int p = 0; p < 7; p++) begin
      begin_pass(tbl[p].tr, tbl[p].eta, tbl[p].ld_en, tbl[p].ld_idx, tbl[p].ld_val, s);
      for (int i = 0; i < N; i++) begin
        feed(2'(i), tbl[p].s[i], tbl[p].d[i], tbl[p].exp_net[i],
             tbl[p].gappy ? 1 + int'($urandom_range(0, 1)) : 0, 0);
      end
      sum_in_vld = 1'b0;
      wait_done(s, !tbl[p].gappy);
    end

    // Clock enable held low for 5 cycles in WAIT of neuron 0.
    begin_pass(1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, s);
    feed(2'd0, 16'h0000, 16'h0000, 16'h0010, 0, 5);
    feed(2'd1, 16'h0000, 16'h0000, 16'hFFF9, 0, 0);
    feed(2'd2, 16'h0000, 16'h0000, 16'h0002, 0, 0);
    feed(2'd3, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    sum_in_vld = 1'b0;
    wait_done(s, 1'b0);

    // Reset during WAIT of a training pass.
    begin_pass(1'b1, 16'h0001, 1'b0, 2'd0, 16'h0000, s);
    t = 0;
    while (sum_in_rdy !== 1'b1 && t < 20) begin
      @(negedge ap_clk);
      t++;
    end
    check("rdy_before_abort", 32'(sum_in_rdy), 32'd1);
    sum_in_vld = 1'b1; sum_in = 16'h0042; delta_k = 16'h0001;
    @(negedge ap_clk);
    sum_in_vld = 1'b0;
    check("state_before_abort", 32'(dbg_state), 32'(ST_WAIT));
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdy", 32'(sum_in_rdy), 32'd0);
    check("abort_pe_sum", 32'(pe_sum_in), 32'd0);
    check("abort_pe_training", 32'(pe_training), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      check("abort_no_done", 32'(done), 32'd0);
    end

    // All biases back to INIT_BIAS; start and load_en while busy are ignored.
    begin_pass(1'b0, 16'h0000, 1'b0, 2'd0, 16'h0000, s);
    feed(2'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    start = 1'b1; training = 1'b1; load_en = 1'b1; load_idx = 2'd3; load_val = 16'h1234;
    @(negedge ap_clk);
    start = 1'b0; load_en = 1'b0;
    check("busy_mid_pass", 32'(busy), 32'd1);
    feed(2'd1, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    feed(2'd2, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    feed(2'd3, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    sum_in_vld = 1'b0;
    wait_done(s, 1'b1);
    repeat (3) @(negedge ap_clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
